// File: rtl/comp_serial_if.sv
// rtl/comp_serial_if.sv - digit-pair stream and result flags of the serial comparator
interface comp_serial_if;
   logic       start;
   logic       neg;
   logic       valid_in;
   logic       ready_in;
   logic [1:0] x_dig;
   logic [1:0] y_dig;
   logic       busy;
   logic       done;
   logic       gt;
   logic       eq;
   logic       lt;

   modport slave (
      input  start, neg, valid_in, x_dig, y_dig,
      output ready_in, busy, done, gt, eq, lt
   );

   modport master (
      output start, neg, valid_in, x_dig, y_dig,
      input  ready_in, busy, done, gt, eq, lt
   );
endinterface

// File: rtl/comp_serial.sv
// rtl/comp_serial.sv - digit-serial MSB-first magnitude comparator with optional signed mode
module comp_serial #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   comp_serial_if.slave bus
);
   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_neg;
   logic          r_flip;
   logic          r_run_gt;
   logic          r_run_eq;
   logic          r_run_lt;
   logic          r_gt;
   logic          r_eq;
   logic          r_lt;

   logic          w_ready;
   logic          w_busy;
   logic          w_done;
   logic          w_accept;
   logic          w_last;
   logic          w_flip;
   logic          w_ngt;
   logic          w_neq;
   logic          w_nlt;

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_ready  = 1'b0;
      w_busy   = 1'b0;
      w_done   = 1'b0;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = S_SCAN;
            end
         end
         S_SCAN: begin
            w_ready  = 1'b1;
            w_busy   = 1'b1;
            w_accept = bus.valid_in;
            if (w_accept && w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The sign digit differs only on the first accept; a differing sign inverts the magnitude verdict.
   assign w_flip = (r_cnt == '0) ? (r_neg & (bus.x_dig[1] ^ bus.y_dig[1])) : r_flip;
   assign w_ngt  = r_run_eq ? (bus.x_dig > bus.y_dig)  : r_run_gt;
   assign w_nlt  = r_run_eq ? (bus.x_dig < bus.y_dig)  : r_run_lt;
   assign w_neq  = r_run_eq ? (bus.x_dig == bus.y_dig) : 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_flip   <= 1'b0;
         r_run_gt <= 1'b0;
         r_run_eq <= 1'b0;
         r_run_lt <= 1'b0;
         r_gt     <= 1'b0;
         r_eq     <= 1'b1;
         r_lt     <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_neg    <= bus.neg;
            r_cnt    <= '0;
            r_flip   <= 1'b0;
            r_run_gt <= 1'b0;
            r_run_eq <= 1'b1;
            r_run_lt <= 1'b0;
         end
         if (w_accept) begin
            r_cnt    <= r_cnt + CW'(1);
            r_flip   <= w_flip;
            r_run_gt <= w_ngt;
            r_run_eq <= w_neq;
            r_run_lt <= w_nlt;
            // Visible flags change only as the FSM enters DONE.
            if (w_last) begin
               r_gt <= w_ngt ^ w_flip;
               r_eq <= w_neq;
               r_lt <= w_nlt ^ w_flip;
            end
         end
      end
   end

   assign bus.ready_in = w_ready;
   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.gt       = r_gt;
   assign bus.eq       = r_eq;
   assign bus.lt       = r_lt;
endmodule

// File: tb/tb_comp_serial.sv
// tb/tb_comp_serial.sv - randomized self-checking bench for comp_serial against an integer model
module tb_comp_serial;
   localparam int N = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   comp_serial_if ifc ();

   comp_serial #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] flags();
      return {ifc.gt, ifc.eq, ifc.lt};
   endfunction

   // Whole-operand reference: plain integer comparison, signed or unsigned.
   function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y, input logic sn);
      int a;
      int b;
      if (sn) begin
         a = int'($signed(x));
         b = int'($signed(y));
      end else begin
         a = int'({24'd0, x});
         b = int'({24'd0, y});
      end
      if (a > b) return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
   endfunction

   // Drives one full comparison; returns latency in edges from the start-sampling edge to done.
   task automatic do_compare(input logic [7:0] x, input logic [7:0] y, input logic sn,
                             input int gap, input bit poke_scan, input bit poke_done,
                             output int lat, output int gaps, output logic [2:0] res,
                             output bit hold_ok);
      logic [2:0] prev;
      int g;
      prev    = flags();
      hold_ok = 1'b1;
      gaps    = 0;
      ifc.start = 1'b1;
      ifc.neg   = sn;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      ifc.neg   = ~sn;
      lat = 1;
      for (int d = 0; d < N; d++) begin
         g = (d == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
         for (int k = 0; k < g; k++) begin
            ifc.valid_in = 1'b0;
            ifc.x_dig    = 2'($urandom);
            ifc.y_dig    = 2'($urandom);
            if (ifc.ready_in !== 1'b1 || ifc.busy !== 1'b1 || ifc.done !== 1'b0 || flags() !== prev)
               hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            gaps++;
         end
         ifc.valid_in = 1'b1;
         ifc.x_dig    = x[2*(N-1-d) +: 2];
         ifc.y_dig    = y[2*(N-1-d) +: 2];
         ifc.start    = poke_scan && (d == 1);
         if (ifc.ready_in !== 1'b1 || ifc.busy !== 1'b1 || ifc.done !== 1'b0 || flags() !== prev)
            hold_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
         ifc.start = 1'b0;
      end
      ifc.valid_in = 1'b0;
      while (ifc.done !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      res = flags();
      if (ifc.ready_in !== 1'b0 || ifc.busy !== 1'b0) hold_ok = 1'b0;
      ifc.start = poke_done;
      @(posedge clk); #1;
      ifc.start = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (flags() !== 3'b010) begin failures++; $display("FAIL reset_flags: got %b want 010", flags()); end
      checks++; if ({ifc.ready_in, ifc.busy, ifc.done} !== 3'b000) begin failures++;
         $display("FAIL reset_ctrl: got rdy/busy/done=%b want 000", {ifc.ready_in, ifc.busy, ifc.done}); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if ({ifc.ready_in, ifc.busy, ifc.done} !== 3'b000 || flags() !== 3'b010) begin failures++;
         $display("FAIL idle_after_reset: got ctrl=%b flags=%b want 000/010", {ifc.ready_in, ifc.busy, ifc.done}, flags()); end
   endtask

   task automatic test_unsigned();
      int lat, gaps; logic [2:0] res; bit ok;
      do_compare(8'hB4, 8'hB2, 1'b0, 0, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (lat !== N + 1) begin failures++; $display("FAIL unsigned_latency: got %0d want %0d", lat, N + 1); end
      checks++; if (res !== 3'b100) begin failures++; $display("FAIL unsigned_b4_b2: got %b want 100", res); end
      checks++; if (!ok) begin failures++; $display("FAIL unsigned_scan_ctrl: got 0 want 1"); end
      checks++; if (ifc.done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b want 0", ifc.done); end
   endtask

   task automatic test_signed();
      int lat, gaps; logic [2:0] res; bit ok;
      do_compare(8'h80, 8'h01, 1'b1, 0, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (res !== 3'b001) begin failures++; $display("FAIL signed_80_01: got %b want 001", res); end
      do_compare(8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (res !== 3'b100) begin failures++; $display("FAIL unsigned_80_01: got %b want 100", res); end
      do_compare(8'hFF, 8'h7F, 1'b1, 0, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (res !== 3'b001) begin failures++; $display("FAIL signed_ff_7f: got %b want 001", res); end
   endtask

   task automatic test_gaps();
      int lat, gaps; logic [2:0] res; bit ok;
      do_compare(8'h5A, 8'h5A, 1'b0, 2, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (lat !== 11) begin failures++; $display("FAIL gap_latency: got %0d want 11", lat); end
      checks++; if (res !== 3'b010) begin failures++; $display("FAIL gap_equal: got %b want 010", res); end
      checks++; if (!ok) begin failures++; $display("FAIL gap_ready_hold: got 0 want 1"); end
   endtask

   task automatic test_reset_mid();
      int lat, gaps; logic [2:0] res; bit ok, saw_done; logic [7:0] x, y;
      do_compare(8'hB4, 8'hB2, 1'b0, 0, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (res !== 3'b100) begin failures++; $display("FAIL pre_reset_gt: got %b want 100", res); end
      ifc.start = 1'b1; ifc.neg = 1'b0;
      @(posedge clk); #1;
      ifc.start = 1'b0; ifc.valid_in = 1'b1; ifc.x_dig = 2'b00; ifc.y_dig = 2'b11;
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      checks++; if (flags() !== 3'b010 || ifc.busy !== 1'b0 || ifc.ready_in !== 1'b0 || ifc.done !== 1'b0) begin failures++;
         $display("FAIL mid_reset: got flags=%b busy=%b rdy=%b done=%b want 010/0/0/0", flags(), ifc.busy, ifc.ready_in, ifc.done); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      saw_done = 1'b0;
      repeat (4) begin
         if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      ifc.valid_in = 1'b0;
      checks++; if (saw_done) begin failures++; $display("FAIL mid_reset_no_done: got activity=1 want 0"); end
      x = 8'($urandom); y = 8'($urandom);
      do_compare(x, y, 1'b1, -1, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (res !== ref_cmp(x, y, 1'b1)) begin failures++;
         $display("FAIL post_reset_compare: x=%h y=%h got %b want %b", x, y, res, ref_cmp(x, y, 1'b1)); end
   endtask

   task automatic test_ignored_start();
      int lat, gaps; logic [2:0] res, held; bit ok, idle_ok; logic [7:0] x, y;
      x = 8'($urandom); y = 8'($urandom);
      do_compare(x, y, 1'b0, 1, 1'b1, 1'b1, lat, gaps, res, ok);
      checks++; if (lat !== N + 1 + (N - 1)) begin failures++; $display("FAIL ignored_start_latency: got %0d want %0d", lat, 2 * N); end
      checks++; if (res !== ref_cmp(x, y, 1'b0)) begin failures++;
         $display("FAIL ignored_start_result: x=%h y=%h got %b want %b", x, y, res, ref_cmp(x, y, 1'b0)); end
      held = res; idle_ok = 1'b1;
      repeat (4) begin
         if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || flags() !== held) idle_ok = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (!idle_ok) begin failures++; $display("FAIL start_in_done_ignored: got 0 want 1"); end
   endtask

   task automatic test_flag_hold();
      int lat, gaps; logic [2:0] res; bit ok;
      do_compare(8'hB4, 8'hB2, 1'b0, 0, 1'b0, 1'b0, lat, gaps, res, ok);
      do_compare(8'h00, 8'hFF, 1'b0, 1, 1'b0, 1'b0, lat, gaps, res, ok);
      checks++; if (!ok) begin failures++; $display("FAIL flag_hold_scan: got 0 want 1"); end
      checks++; if (res !== 3'b001) begin failures++; $display("FAIL flag_hold_result: got %b want 001", res); end
   endtask

   task automatic test_random();
      int lat, gaps; logic [2:0] res, exp; bit ok; logic [7:0] x, y; logic sn;
      for (int i = 0; i < 60; i++) begin
         x  = 8'($urandom);
         y  = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
         sn = 1'($urandom);
         do_compare(x, y, sn, -1, 1'b0, 1'b0, lat, gaps, res, ok);
         exp = ref_cmp(x, y, sn);
         checks++; if (res !== exp) begin failures++;
            $display("FAIL random_result[%0d]: x=%h y=%h neg=%b got %b want %b", i, x, y, sn, res, exp); end
         checks++; if (lat !== N + 1 + gaps) begin failures++;
            $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, N + 1 + gaps); end
         checks++; if (!ok) begin failures++; $display("FAIL random_scan_ctrl[%0d]: got 0 want 1", i); end
      end
   endtask

   initial begin
      ifc.start    = 1'b0;
      ifc.neg      = 1'b0;
      ifc.valid_in = 1'b0;
      ifc.x_dig    = 2'b00;
      ifc.y_dig    = 2'b00;
      test_reset();
      test_unsigned();
      test_signed();
      test_gaps();
      test_reset_mid();
      test_ignored_start();
      test_flag_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
